// File: rtl/cache_mem_arbiter_pkg.sv
// cache_mem_arbiter_pkg: shared types for the I/D-cache to main-memory arbiter.
// Optional feature macro used by the arbiter: CACHE_ARB_ROUND_ROBIN_EN.
package cache_mem_arbiter_pkg;

  // Default block (memory word) width and block-address width. The latched
  // access struct is sized from these. Instances may use narrower widths.
  localparam int CACHE_BLOCK_SIZE = 64;
  localparam int ARB_ADDR_WIDTH   = 16;

  // Arbiter control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Requester identity.
  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } arb_src_t;

  // Memory access captured at grant time. It drives the memory port for
  // the whole BUSY phase.
  typedef struct packed {
    logic                        we;
    logic [ARB_ADDR_WIDTH-1:0]   addr;
    logic [CACHE_BLOCK_SIZE-1:0] wdata;
  } mem_access_t;

  // Returns the requester that is not the given one.
  function automatic arb_src_t other_src(input arb_src_t s);
    return (s == SRC_I) ? SRC_D : SRC_I;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if: cache request/ack channels plus the main-memory port.
//
// Handshake rules on every channel:
//   - A cache raises *_req with stable fields and holds them until its
//     *_ack pulse. It drops *_req in the cycle after the ack.
//   - *_ack is a one-cycle pulse. *_rdata is valid only while *_ack is high.
//   - mem_req is held with stable fields until a one-cycle mem_done pulse.
//     mem_rdata is valid only while mem_done is high.
//   - idle is high when the arbiter is parked with no request pending.
// The slave modport is the arbiter's view. The master modport is the
// environment's view: the caches and the memory.
interface cache_mem_arbiter_if
  import cache_mem_arbiter_pkg::*;
#(
  parameter int BLOCK_BITS = CACHE_BLOCK_SIZE,
  parameter int ADDR_WIDTH = ARB_ADDR_WIDTH
);

  // I-cache channel
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_ack;
  logic [BLOCK_BITS-1:0] i_rdata;

  // D-cache channel
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [BLOCK_BITS-1:0] d_wdata;
  logic                  d_ack;
  logic [BLOCK_BITS-1:0] d_rdata;

  // Main-memory port
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [BLOCK_BITS-1:0] mem_wdata;
  logic [BLOCK_BITS-1:0] mem_rdata;
  logic                  mem_done;

  // Drain indication for the core
  logic                  idle;

  modport slave (
    input  i_req, i_addr,
    output i_ack, i_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_ack, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_done,
    output idle
  );

  modport master (
    output i_req, i_addr,
    input  i_ack, i_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_ack, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_done,
    input  idle
  );

endinterface

// File: rtl/cache_mem_arbiter_arb_pick.sv
// arb_pick: two-way grant select between the I-cache and the D-cache.
// With CACHE_ARB_ROUND_ROBIN_EN defined, a tie goes to the requester that was
// not granted most recently. A "last granted" register tracks this, and it
// resets to SRC_I so that D wins the first tie.
// Without the macro, the D-cache always wins a tie and there is no state.
module arb_pick
  import cache_mem_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     i_req_i,
  input  logic     d_req_i,
  input  logic     grant_en_i,   // high when the arbiter is able to grant
  output logic     gnt_valid_o,
  output arb_src_t gnt_src_o
);

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  arb_src_t last_q, last_d;

  // Grant select: a single requester wins outright, and a tie is resolved
  // against the last winner.
  always_comb begin
    gnt_valid_o = i_req_i | d_req_i;
    gnt_src_o   = SRC_D;
    if (i_req_i && d_req_i) begin
      gnt_src_o = other_src(last_q);
    end else if (i_req_i) begin
      gnt_src_o = SRC_I;
    end
  end

  // The pointer advances on every actual grant, contended or not.
  always_comb begin
    last_d = last_q;
    if (grant_en_i && gnt_valid_o) begin
      last_d = gnt_src_o;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= SRC_I;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority has no state, so the clock and reset are left unused.
  logic unused_clk_rst;
  logic unused_grant_en;
  assign unused_clk_rst  = clk ^ rst;
  assign unused_grant_en = grant_en_i;

  // Grant select: the D-cache wins every tie.
  always_comb begin
    gnt_valid_o = i_req_i | d_req_i;
    gnt_src_o   = SRC_D;
    if (i_req_i && !d_req_i) begin
      gnt_src_o = SRC_I;
    end
  end
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: places I-cache and D-cache block refills and writebacks
// onto the single main-memory port.
// Sequence per access: IDLE (grant and latch) -> BUSY (hold mem_req until
// mem_done) -> RESP (one-cycle ack to the granted cache).
// The CACHE_ARB_ROUND_ROBIN_EN macro selects round-robin tie breaking inside
// arb_pick. The default build uses fixed D-over-I priority.
// Every output except idle is driven from a register.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int BLOCK_BITS = CACHE_BLOCK_SIZE,  // at most CACHE_BLOCK_SIZE
  parameter int ADDR_WIDTH = ARB_ADDR_WIDTH     // at most ARB_ADDR_WIDTH
)(
  input  logic                clk,
  input  logic                rst,
  cache_mem_arbiter_if.slave  bus,
  output arb_state_t          state_o       // FSM state for debug and checkers
);

  arb_state_t            state_q,   state_d;
  arb_src_t              src_q,     src_d;
  mem_access_t           acc_q,     acc_d;
  logic                  mem_req_q, mem_req_d;
  logic                  i_ack_q,   i_ack_d;
  logic                  d_ack_q,   d_ack_d;
  logic [BLOCK_BITS-1:0] i_rdata_q, i_rdata_d;
  logic [BLOCK_BITS-1:0] d_rdata_q, d_rdata_d;

  logic                  grant_en;
  logic                  gnt_valid;
  arb_src_t              gnt_src;

  arb_pick u_pick (
    .clk         (clk),
    .rst         (rst),
    .i_req_i     (bus.i_req),
    .d_req_i     (bus.d_req),
    .grant_en_i  (grant_en),
    .gnt_valid_o (gnt_valid),
    .gnt_src_o   (gnt_src)
  );

  // Next-state and register-input logic for the arbiter FSM.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    acc_d     = acc_q;
    mem_req_d = mem_req_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    grant_en  = 1'b0;

    case (state_q)
      IDLE: begin
        grant_en = 1'b1;
        if (gnt_valid) begin
          state_d   = BUSY;
          src_d     = gnt_src;
          mem_req_d = 1'b1;
          if (gnt_src == SRC_D) begin
            acc_d.we    = bus.d_we;
            acc_d.addr  = ARB_ADDR_WIDTH'(bus.d_addr);
            acc_d.wdata = CACHE_BLOCK_SIZE'(bus.d_wdata);
          end else begin
            // The I-cache only reads. Zero the write fields so the
            // memory port does not carry stale writeback data.
            acc_d.we    = 1'b0;
            acc_d.addr  = ARB_ADDR_WIDTH'(bus.i_addr);
            acc_d.wdata = '0;
          end
        end
      end

      BUSY: begin
        // The latched access stays on the port until memory completes.
        // Requests that arrive in the meantime wait in IDLE.
        if (bus.mem_done) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (src_q == SRC_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = bus.mem_rdata;
          end else begin
            d_ack_d = 1'b1;
            if (!acc_q.we) begin
              d_rdata_d = bus.mem_rdata;
            end
          end
        end
      end

      RESP: begin
        // The ack registers carry the one-cycle pulse during this state.
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers. A reset aborts any access in flight and
  // does not issue an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      src_q     <= SRC_I;
      acc_q     <= '0;
      mem_req_q <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      acc_q     <= acc_d;
      mem_req_q <= mem_req_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = acc_q.we;
  assign bus.mem_addr  = ADDR_WIDTH'(acc_q.addr);
  assign bus.mem_wdata = BLOCK_BITS'(acc_q.wdata);
  assign bus.i_ack     = i_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;

  // idle is combinational so the core sees a fresh request at once.
  assign bus.idle = (state_q == IDLE) & ~bus.i_req & ~bus.d_req;

  assign state_o = state_q;

endmodule
